// File: rtl/mem_stage_lsu_pkg.sv
// Shared types for the MEM-stage load/store unit.
//   lsu_state_t         : LSU FSM encoding (IDLE / BUSY / DONE)
//   rv32i_ctrl_t        : control word carried down the pipeline
//   ex_mem_pipeline_reg : EX/MEM register contents (bubble = ctrl all zero)
//   mem_wb_pipeline_reg : MEM/WB register contents (mdr holds the raw word)
package mem_stage_lsu_pkg;

  typedef enum logic [1:0] {LSU_IDLE, LSU_BUSY, LSU_DONE} lsu_state_t;

  // funct3 encodings of the RV32I loads/stores that matter for alignment
  localparam logic [2:0] F3_BYTE  = 3'b000;
  localparam logic [2:0] F3_HALF  = 3'b001;
  localparam logic [2:0] F3_WORD  = 3'b010;
  localparam logic [2:0] F3_BYTEU = 3'b100;
  localparam logic [2:0] F3_HALFU = 3'b101;

  typedef struct packed {
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [4:0] rd;
    logic       load_regfile;
    logic       mem_read;
    logic       mem_write;
  } rv32i_ctrl_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ir;
    logic [31:0] alu_out;          // effective address for loads/stores
    logic [31:0] mem_data_out;     // store data, already lane-shifted in EX
    logic [3:0]  write_read_mask;
    logic        br_en;
    logic [31:0] imm;
    logic [31:0] target_address;
    rv32i_ctrl_t ctrl;
  } ex_mem_pipeline_reg;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ir;
    logic [31:0] alu_out;
    logic [31:0] mdr;              // raw loaded word; WB extracts/extends
    logic [3:0]  write_read_mask;
    logic        br_en;
    logic [31:0] imm;
    logic [31:0] target_address;
    rv32i_ctrl_t ctrl;
  } mem_wb_pipeline_reg;

  function automatic logic is_access(input rv32i_ctrl_t c);
    return c.mem_read | c.mem_write;
  endfunction

endpackage

// File: rtl/mem_stage_lsu_if.sv
// Data-cache port between the MEM stage and the data cache.
//   dmem_address : word-aligned byte address
//   dmem_read    : read request
//   dmem_write   : write request
//   dmem_wdata   : store data (lane-shifted)
//   dmem_mbe     : byte enables
//   dmem_rdata   : read data, meaningful only while dmem_resp=1
//   dmem_resp    : one-cycle completion pulse
// Handshake: a request (read or write) is held high with address, data and
// mask stable from the cycle it rises until the cycle dmem_resp is sampled
// high (inclusive); dmem_resp may arrive in the very first request cycle.
// The request is then dropped unless a new access follows immediately.
// A request may only be abandoned by a reset of the requester.
interface mem_stage_lsu_if;
  logic [31:0] dmem_address;
  logic        dmem_read;
  logic        dmem_write;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_mbe;
  logic [31:0] dmem_rdata;
  logic        dmem_resp;

  modport master (
    output dmem_address, dmem_read, dmem_write, dmem_wdata, dmem_mbe,
    input  dmem_rdata, dmem_resp
  );

  modport slave (
    input  dmem_address, dmem_read, dmem_write, dmem_wdata, dmem_mbe,
    output dmem_rdata, dmem_resp
  );
endinterface

// File: rtl/mem_stage_lsu_misalign_check.sv
// Combinational alignment check for loads/stores.
//   access     : in  instruction performs a data access
//   funct3     : in  access width encoding
//   addr_lo    : in  low two address bits
//   misaligned : out word access not 4-byte aligned or halfword access on an
//                odd address; forced low when MISALIGN_CHECK=0
module lsu_misalign_check
  import mem_stage_lsu_pkg::*;
#(
  parameter int unsigned MISALIGN_CHECK = 1
) (
  input  logic       access,
  input  logic [2:0] funct3,
  input  logic [1:0] addr_lo,
  output logic       misaligned
);

  logic is_word;
  logic is_half;

  always_comb begin
    is_word = 1'b0;
    is_half = 1'b0;
    case (funct3)
      F3_WORD:           is_word = 1'b1;
      F3_HALF, F3_HALFU: is_half = 1'b1;
      default: ;                         // byte accesses are always aligned
    endcase
    misaligned = (MISALIGN_CHECK != 0) && access &&
                 ((is_word && (addr_lo != 2'b00)) || (is_half && addr_lo[0]));
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM stage of the 5-stage RV32I pipeline.
// Issues the EX/MEM access on the data-cache port, stalls the pipeline while
// it is outstanding, parks a completed access if the rest of the pipeline is
// frozen, and registers the MEM/WB contents.
//   clk, rst       : clock; synchronous active-high reset
//   ex_mem_i       : EX/MEM register contents
//   ext_stall_i    : freeze from IF/hazard logic
//   dmem           : data-cache port (master side)
//   mem_stall      : access outstanding; freeze PC/IF/ID/EX/MEM registers
//   mem_wb_o       : registered MEM/WB contents
//   misalign_o     : sticky misaligned-access flag
//   stall_cycles_o : wrapping count of cycles with mem_stall=1
//   state_o        : current FSM state (debug)
module mem_stage_lsu
  import mem_stage_lsu_pkg::*;
#(
  parameter int unsigned MISALIGN_CHECK = 1,
  parameter int unsigned CNT_WIDTH      = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  ex_mem_pipeline_reg   ex_mem_i,
  input  logic                 ext_stall_i,
  mem_stage_lsu_if.master      dmem,
  output logic                 mem_stall,
  output mem_wb_pipeline_reg   mem_wb_o,
  output logic                 misalign_o,
  output logic [CNT_WIDTH-1:0] stall_cycles_o,
  output lsu_state_t           state_o
);

  lsu_state_t         state_q;
  lsu_state_t         state_d;
  logic [31:0]        hold_q;       // word captured when completion is parked
  logic               access;
  logic               misaligned;
  logic               issue;
  logic               req;
  logic               stall_c;
  logic               resp_now;     // request active and cache answered
  logic               advance;
  logic [31:0]        mdr_d;
  mem_wb_pipeline_reg mem_wb_d;

  assign access = is_access(ex_mem_i.ctrl);

  lsu_misalign_check #(
    .MISALIGN_CHECK(MISALIGN_CHECK)
  ) u_misalign (
    .access    (access),
    .funct3    (ex_mem_i.ctrl.funct3),
    .addr_lo   (ex_mem_i.alu_out[1:0]),
    .misaligned(misaligned)
  );

  // Misaligned ops never reach the cache; they flow through as if no access.
  assign issue = access & ~misaligned;

  // Next-state and request logic. The request is combinational from the
  // state and ex_mem_i, so it can be answered in its first cycle.
  always_comb begin
    state_d  = state_q;
    req      = 1'b0;
    stall_c  = 1'b0;
    resp_now = 1'b0;
    unique case (state_q)
      LSU_IDLE: begin
        if (issue) begin
          req = 1'b1;
          if (dmem.dmem_resp) begin
            resp_now = 1'b1;
            if (ext_stall_i) state_d = LSU_DONE;
          end else begin
            stall_c = 1'b1;
            state_d = LSU_BUSY;
          end
        end
      end
      LSU_BUSY: begin
        req = 1'b1;
        if (dmem.dmem_resp) begin
          resp_now = 1'b1;
          state_d  = ext_stall_i ? LSU_DONE : LSU_IDLE;
        end else begin
          stall_c = 1'b1;
        end
      end
      LSU_DONE: begin
        // Access already completed; wait for the freeze to lift.
        if (!ext_stall_i) state_d = LSU_IDLE;
      end
      default: state_d = LSU_IDLE;
    endcase
  end

  assign dmem.dmem_read    = req & ~rst & ex_mem_i.ctrl.mem_read;
  assign dmem.dmem_write   = req & ~rst & ex_mem_i.ctrl.mem_write;
  assign dmem.dmem_address = {ex_mem_i.alu_out[31:2], 2'b00};
  assign dmem.dmem_wdata   = ex_mem_i.mem_data_out;
  assign dmem.dmem_mbe     = ex_mem_i.write_read_mask;
  assign mem_stall         = stall_c & ~rst;
  assign advance           = ~mem_stall & ~ext_stall_i;
  assign state_o           = state_q;

  // MDR source: live cache data on a completing load, the parked word when
  // leaving DONE, otherwise zero (stores, bubbles, misaligned ops).
  always_comb begin
    mdr_d = 32'h0;
    if (resp_now && ex_mem_i.ctrl.mem_read) begin
      mdr_d = dmem.dmem_rdata;
    end else if (state_q == LSU_DONE) begin
      mdr_d = hold_q;
    end
  end

  always_comb begin
    mem_wb_d                 = '0;
    mem_wb_d.pc              = ex_mem_i.pc;
    mem_wb_d.ir              = ex_mem_i.ir;
    mem_wb_d.alu_out         = ex_mem_i.alu_out;
    mem_wb_d.mdr             = mdr_d;
    mem_wb_d.write_read_mask = ex_mem_i.write_read_mask;
    mem_wb_d.br_en           = ex_mem_i.br_en;
    mem_wb_d.imm             = ex_mem_i.imm;
    mem_wb_d.target_address  = ex_mem_i.target_address;
    mem_wb_d.ctrl            = ex_mem_i.ctrl;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= LSU_IDLE;
      hold_q         <= 32'h0;
      mem_wb_o       <= '0;
      misalign_o     <= 1'b0;
      stall_cycles_o <= '0;
    end else begin
      state_q <= state_d;
      if (advance) mem_wb_o <= mem_wb_d;
      // Park the result when completion coincides with an external freeze.
      if (resp_now && ext_stall_i) begin
        hold_q <= ex_mem_i.ctrl.mem_read ? dmem.dmem_rdata : 32'h0;
      end
      if (misaligned && (state_q == LSU_IDLE)) misalign_o <= 1'b1;
      if (mem_stall) stall_cycles_o <= stall_cycles_o + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_mem_stage_lsu.sv
module tb_mem_stage_lsu;
  import mem_stage_lsu_pkg::*;

  localparam int MW = $bits(mem_wb_pipeline_reg);

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // ---------------- DUT wiring ----------------
  ex_mem_pipeline_reg ex_mem, ex_mem2;
  logic               ext_stall, ext_stall2;
  logic               mem_stall, mem_stall2;
  mem_wb_pipeline_reg mem_wb, mem_wb2;
  logic               misalign, misalign2;
  logic [31:0]        stall_cnt, stall_cnt2;
  lsu_state_t         state, state2;

  mem_stage_lsu_if dif();
  mem_stage_lsu_if dif2();

  mem_stage_lsu #(.MISALIGN_CHECK(1), .CNT_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .ex_mem_i(ex_mem), .ext_stall_i(ext_stall),
    .dmem(dif.master), .mem_stall(mem_stall), .mem_wb_o(mem_wb),
    .misalign_o(misalign), .stall_cycles_o(stall_cnt), .state_o(state)
  );

  // Second instance with the alignment check disabled; its cache always
  // answers in the request cycle with a fixed word.
  mem_stage_lsu #(.MISALIGN_CHECK(0), .CNT_WIDTH(32)) dut_nochk (
    .clk(clk), .rst(rst), .ex_mem_i(ex_mem2), .ext_stall_i(ext_stall2),
    .dmem(dif2.master), .mem_stall(mem_stall2), .mem_wb_o(mem_wb2),
    .misalign_o(misalign2), .stall_cycles_o(stall_cnt2), .state_o(state2)
  );
  assign dif2.dmem_resp  = dif2.dmem_read | dif2.dmem_write;
  assign dif2.dmem_rdata = 32'hCAFE_F00D;

  // ---------------- scoreboard state ----------------
  int          n_checks = 0;
  int          n_errors = 0;
  logic [MW-1:0] exp_q[$];
  logic [31:0] model_mem[16];
  logic [31:0] resp_mem[16];
  bit          exp_mis = 1'b0;
  int          exp_stall_total = 0;
  int          cur_lat = 1;
  int          trains = 0;
  bit          mon_en = 1'b0;
  bit          pending = 1'b0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Alignment rule straight from the ISA: words on 4, halves on 2.
  function automatic bit needs_align(input logic [2:0] f3, input logic [1:0] lo);
    case (f3)
      3'b010:         return lo != 2'b00;
      3'b001, 3'b101: return lo[0];
      default:        return 1'b0;
    endcase
  endfunction

  // kind: 0 bubble, 1 lw, 2 lh, 3 lhu, 4 lb, 5 sw, 6 sh, 7 sb
  function automatic ex_mem_pipeline_reg mk_op(input int kind, input logic [31:0] addr);
    ex_mem_pipeline_reg op;
    op.pc              = $urandom;
    op.ir              = $urandom;
    op.alu_out         = addr;
    op.mem_data_out    = $urandom;
    op.write_read_mask = 4'($urandom_range(0, 15));
    op.br_en           = 1'($urandom_range(0, 1));
    op.imm             = $urandom;
    op.target_address  = $urandom;
    op.ctrl            = '0;
    if (kind != 0) begin
      op.ctrl.rd = 5'($urandom_range(1, 31));
      case (kind)
        1: op.ctrl.funct3 = 3'b010;
        2: op.ctrl.funct3 = 3'b001;
        3: op.ctrl.funct3 = 3'b101;
        4: op.ctrl.funct3 = 3'b000;
        5: op.ctrl.funct3 = 3'b010;
        6: op.ctrl.funct3 = 3'b001;
        default: op.ctrl.funct3 = 3'b000;
      endcase
      if (kind <= 4) begin
        op.ctrl.opcode       = 7'b0000011;
        op.ctrl.mem_read     = 1'b1;
        op.ctrl.load_regfile = 1'b1;
      end else begin
        op.ctrl.opcode    = 7'b0100011;
        op.ctrl.mem_write = 1'b1;
      end
    end
    return op;
  endfunction

  // ---------------- cache responder ----------------
  // Runs 2 time units after the edge, once the driver has updated inputs.
  bit          in_train = 1'b0;
  int          rcnt = 0;
  logic [68:0] snap;

  always @(posedge clk) begin
    logic [3:0] idx;
    #2;
    if (dif.dmem_resp) begin
      dif.dmem_resp = 1'b0;
      in_train      = 1'b0;
    end
    dif.dmem_rdata = $urandom;
    if (rst || !(dif.dmem_read || dif.dmem_write)) begin
      in_train = 1'b0;
    end else begin
      if (!in_train) begin
        in_train = 1'b1;
        rcnt     = 1;
        trains++;
        snap = {dif.dmem_address, dif.dmem_wdata, dif.dmem_mbe, dif.dmem_read};
      end else begin
        rcnt++;
        check("req_stable", {dif.dmem_address, dif.dmem_wdata, dif.dmem_mbe, dif.dmem_read}, snap);
      end
      if (rcnt == cur_lat) begin
        dif.dmem_resp = 1'b1;
        idx = dif.dmem_address[5:2];
        if (dif.dmem_read) begin
          dif.dmem_rdata = resp_mem[idx];
        end else begin
          for (int b = 0; b < 4; b++)
            if (dif.dmem_mbe[b]) resp_mem[idx][8*b +: 8] = dif.dmem_wdata[8*b +: 8];
        end
      end
    end
  end

  // ---------------- monitor ----------------
  // An advance sampled at one falling edge is checked at the next one.
  always @(negedge clk) begin
    logic [MW-1:0] e;
    if (pending) begin
      pending = 1'b0;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL mem_wb_extra: got 0x%0h expected no advance at %0t", mem_wb, $time);
      end else begin
        e = exp_q.pop_front();
        check("mem_wb", mem_wb, e);
      end
    end
    if (mon_en && !rst && !mem_stall && !ext_stall) pending = 1'b1;
  end

  // ---------------- driver ----------------
  // Called just after a rising edge; returns just after the edge that
  // advanced the op.
  task automatic run_op(input ex_mem_pipeline_reg op, input int lat,
                        input int stall_pre, input bit rand_ext);
    bit ld, st, mis, issued, done;
    int cyc, stalls, tr0;
    logic [3:0] idx;
    mem_wb_pipeline_reg e;
    ld     = op.ctrl.mem_read;
    st     = op.ctrl.mem_write;
    mis    = (ld || st) && needs_align(op.ctrl.funct3, op.alu_out[1:0]);
    issued = (ld || st) && !mis;
    idx    = op.alu_out[5:2];
    e.pc              = op.pc;
    e.ir              = op.ir;
    e.alu_out         = op.alu_out;
    e.mdr             = (issued && ld) ? model_mem[idx] : 32'h0;
    e.write_read_mask = op.write_read_mask;
    e.br_en           = op.br_en;
    e.imm             = op.imm;
    e.target_address  = op.target_address;
    e.ctrl            = op.ctrl;
    if (issued && st)
      for (int b = 0; b < 4; b++)
        if (op.write_read_mask[b]) model_mem[idx][8*b +: 8] = op.mem_data_out[8*b +: 8];
    exp_q.push_back(e);
    cur_lat = lat;
    ex_mem  = op;
    tr0     = trains;
    stalls  = 0;
    cyc     = 0;
    done    = 1'b0;
    while (!done) begin
      ext_stall = (cyc < stall_pre) || (rand_ext && ($urandom_range(0, 3) == 0));
      @(negedge clk);
      if (cyc == 0) begin
        check("misalign_flag", misalign, exp_mis);
        check("req_lines", {dif.dmem_read, dif.dmem_write}, issued ? {ld, st} : 2'b00);
      end
      if (issued && stall_pre >= lat && cyc == lat)
        check("done_park", {state, dif.dmem_read, dif.dmem_write}, {LSU_DONE, 2'b00});
      if (mem_stall) stalls++;
      if (!mem_stall && !ext_stall) begin
        done = 1'b1;
      end else if (cyc >= 60) begin
        n_checks++;
        n_errors++;
        $display("FAIL advance_timeout: got no advance after %0d cycles expected one", cyc);
        done = 1'b1;
      end else begin
        @(posedge clk);
        #1;
        cyc++;
      end
    end
    if (mis) exp_mis = 1'b1;
    if (issued) exp_stall_total += lat - 1;
    check("stall_len", stalls, issued ? lat - 1 : 0);
    check("req_trains", trains - tr0, issued ? 1 : 0);
    @(posedge clk);
    #1;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    rst           = 1'b1;
    ext_stall     = 1'b0;
    ext_stall2    = 1'b0;
    dif.dmem_resp = 1'b0;
    dif.dmem_rdata = 32'h0;
    ex_mem2       = '0;
    for (int i = 0; i < 16; i++) begin
      model_mem[i] = $urandom;
      resp_mem[i]  = model_mem[i];
    end
    model_mem[0] = 32'hDEAD_BEEF;
    resp_mem[0]  = 32'hDEAD_BEEF;
    ex_mem = mk_op(1, 32'h100);          // a load presented during reset

    @(negedge clk);
    check("rst_no_req", {dif.dmem_read, dif.dmem_write, mem_stall}, 3'b000);
    @(posedge clk); #1;
    @(negedge clk);
    check("rst_mem_wb", mem_wb, '0);
    check("rst_flags", {misalign, stall_cnt}, '0);
    check("rst_state", state, LSU_IDLE);
    @(posedge clk); #1;
    rst    = 1'b0;
    mon_en = 1'b1;

    // Directed cases
    run_op(mk_op(1, 32'h100), 1, 0, 1'b0);   // lw, same-cycle resp
    run_op(mk_op(5, 32'h104), 3, 0, 1'b0);   // sw, resp after 3 cycles
    run_op(mk_op(1, 32'h104), 2, 4, 1'b0);   // lw completes under freeze
    run_op(mk_op(2, 32'h103), 2, 0, 1'b0);   // misaligned lh
    run_op(mk_op(0, 32'h0),   1, 0, 1'b0);   // bubble

    // Randomized traffic
    for (int n = 0; n < 250; n++) begin
      int kind, lat, pre;
      kind = $urandom_range(0, 7);
      lat  = $urandom_range(1, 4);
      pre  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 5) : 0;
      run_op(mk_op(kind, 32'h100 + $urandom_range(0, 63)), lat, pre, 1'($urandom_range(0, 1)));
    end
    check("stall_total", stall_cnt, exp_stall_total);
    check("misalign_sticky", misalign, exp_mis);

    // Check disabled: misaligned lh is issued to the cache
    mon_en    = 1'b0;
    ex_mem    = '0;
    ext_stall = 1'b1;
    ex_mem2   = mk_op(2, 32'h103);
    @(negedge clk);
    check("nochk_req", {dif2.dmem_read, mem_stall2}, 2'b10);
    @(posedge clk); #1;
    ex_mem2 = '0;
    @(negedge clk);
    check("nochk_mdr", mem_wb2.mdr, 32'hCAFE_F00D);
    check("nochk_flag", misalign2, 1'b0);

    // Reset while an access is outstanding
    @(posedge clk); #1;
    cur_lat   = 100;
    ext_stall = 1'b0;
    ex_mem    = mk_op(1, 32'h108);
    @(posedge clk); #1;
    @(negedge clk);
    check("busy_before_rst", {state, mem_stall}, {LSU_BUSY, 1'b1});
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check("rst_drop_req", {dif.dmem_read, dif.dmem_write, mem_stall}, 3'b000);
    @(posedge clk); #1;
    rst       = 1'b0;
    ex_mem    = '0;
    ext_stall = 1'b1;
    @(negedge clk);
    check("post_rst_state", state, LSU_IDLE);
    check("post_rst_mem_wb", mem_wb, '0);
    check("post_rst_cnt", stall_cnt, 32'h0);
    check("post_rst_flag", misalign, 1'b0);

    check("exp_q_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
